// File: rtl/error_classifier.sv
// Error classifier: aligns received/recomputed parity per codeword mode, forms the syndrome and
// reports none/single/double errors through a one-deep valid/ready stage. Optional statistics via `ERR_STATS_EN.
module error_classifier #(
    parameter int PARITY_WIDTH = 6,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              codeword_width,
    input  logic [PARITY_WIDTH-1:0] y_parity,
    input  logic [PARITY_WIDTH-1:0] data_parity,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              nof,
    output logic [PARITY_WIDTH-2:0] fix_pos,
    input  logic                    clr_cnt,
    output logic [CNT_WIDTH-1:0]    cnt_single,
    output logic [CNT_WIDTH-1:0]    cnt_double
);

    localparam int PW = PARITY_WIDTH;

    // Narrower codewords keep their overall parity bit just above the Hamming bits;
    // move it to the MSB so every mode shares one syndrome layout.
    function automatic logic [PW-1:0] align(input logic [PW-1:0] v, input logic [1:0] mode);
        logic [PW-1:0] a;
        a = '0;
        case (mode)
            2'b00: begin
                a[PW-1]   = v[PW-3];
                a[PW-4:0] = v[PW-4:0];
            end
            2'b01: begin
                a[PW-1]   = v[PW-2];
                a[PW-3:0] = v[PW-3:0];
            end
            default: a = v;
        endcase
        return a;
    endfunction

    logic [PW-1:0] syndrome;
    logic [1:0]    nof_next;
    logic [PW-2:0] fix_next;
    logic          transfer;

    assign syndrome = align(y_parity, codeword_width) ^ align(data_parity, codeword_width);
    assign in_ready = ~out_valid | out_ready;
    assign transfer = in_valid & in_ready;

    always_comb begin
        nof_next = 2'b00;
        fix_next = '0;
        if (syndrome[PW-1]) begin
            nof_next = 2'b01;
            fix_next = syndrome[PW-2:0];
        end else if (syndrome[PW-2:0] != '0) begin
            nof_next = 2'b10;
            fix_next = syndrome[PW-2:0];
        end
    end

    // A new beat may replace a result in the same cycle it is accepted, giving full throughput.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            nof       <= 2'b00;
            fix_pos   <= '0;
        end else if (transfer) begin
            out_valid <= 1'b1;
            nof       <= nof_next;
            fix_pos   <= fix_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ERR_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Counters saturate rather than wrap; a clear beats any increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            cnt_single <= '0;
            cnt_double <= '0;
        end else if (transfer) begin
            if (nof_next == 2'b01 && cnt_single != '1)
                cnt_single <= cnt_single + CNT_ONE;
            if (nof_next == 2'b10 && cnt_double != '1)
                cnt_double <= cnt_double + CNT_ONE;
        end
    end
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign cnt_single     = '0;
    assign cnt_double     = '0;
`endif

endmodule
